pio_out_pulse: RTL

- Parametrised Avalon-MM slave output port. Successor to the single-bit software reset/control output register.
- Holds a WIDTH-bit output register with atomic set, clear and toggle write ports.
- Adds a hardware-timed pulse mode. Software requests a pulse on any bits, and the block holds them high for a programmable number of clk cycles, then drops them on its own.
- Sits on the HPS/Nios lightweight bus and drives reset, trigger and strobe lines into the lock-in datapath.

---
 rtl/pio_out_pulse_if.sv | 29 ++
 rtl/pio_out_pulse.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : read data (32 bits), combinational, read latency 0
interface pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_out_pulse.sv
// Avalon-MM output port with atomic set/clear/toggle and a hardware-timed pulse mode.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port   : data_reg | pulse_reg
//   pulse_busy : high while a pulse is active
// Register map: 0 DATA, 1 SET, 2 CLEAR, 3 TOGGLE, 4 PULSE, 5 PULSE_LEN, 6 STATUS, 7 reserved.
module pio_out_pulse #(
  parameter int unsigned       WIDTH             = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE       = '0,
  parameter int unsigned       PULSE_LEN_DEFAULT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_out_pulse_if.slave     bus,
  output logic [WIDTH-1:0]   out_port,
  output logic               pulse_busy
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrSet      = 3'd1;
  localparam logic [2:0] AddrClear    = 3'd2;
  localparam logic [2:0] AddrToggle   = 3'd3;
  localparam logic [2:0] AddrPulse    = 3'd4;
  localparam logic [2:0] AddrPulseLen = 3'd5;
  localparam logic [2:0] AddrStatus   = 3'd6;

  typedef enum logic {StIdle, StActive} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic [WIDTH-1:0] r_pulse, w_pulse_next;
  logic [15:0]      r_cnt, w_cnt_next;
  logic [15:0]      r_pulse_len, w_pulse_len_next;

  logic             w_wr;
  logic             w_pulse_wr;
  logic [WIDTH-1:0] w_wd;
  logic [15:0]      w_wd16;
  logic [31:0]      w_rdata;
  logic             w_unused_wd;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wd        = bus.writedata[WIDTH-1:0];
  assign w_wd16      = bus.writedata[15:0];
  assign w_unused_wd = ^bus.writedata[31:16];
  // A zero-mask PULSE write is a no-op in every state.
  assign w_pulse_wr  = w_wr && (bus.address == AddrPulse) && (w_wd != '0);

  // Data register and pulse length
  always_comb begin
    w_data_next      = r_data;
    w_pulse_len_next = r_pulse_len;
    if (w_wr) begin
      case (bus.address)
        AddrData:     w_data_next = w_wd;
        AddrSet:      w_data_next = r_data | w_wd;
        AddrClear:    w_data_next = r_data & ~w_wd;
        AddrToggle:   w_data_next = r_data ^ w_wd;
        AddrPulseLen: w_pulse_len_next = (w_wd16 == 16'd0) ? 16'd1 : w_wd16;
        default:      ;
      endcase
    end
  end

  // Pulse FSM: a retrigger reloads the counter and wins over expiry in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_pulse_next = r_pulse;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_pulse_wr) begin
          w_pulse_next = w_wd;
          w_cnt_next   = r_pulse_len;
          w_state_next = StActive;
        end
      end
      StActive: begin
        if (w_pulse_wr) begin
          w_pulse_next = r_pulse | w_wd;
          w_cnt_next   = r_pulse_len;
        end else if (r_cnt > 16'd1) begin
          w_cnt_next = r_cnt - 16'd1;
        end else begin
          w_pulse_next = '0;
          w_cnt_next   = 16'd0;
          w_state_next = StIdle;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_data      <= RESET_VALUE;
      r_pulse     <= '0;
      r_cnt       <= 16'd0;
      r_pulse_len <= 16'(PULSE_LEN_DEFAULT);
    end else begin
      r_state     <= w_state_next;
      r_data      <= w_data_next;
      r_pulse     <= w_pulse_next;
      r_cnt       <= w_cnt_next;
      r_pulse_len <= w_pulse_len_next;
    end
  end

  assign pulse_busy = (r_state == StActive);
  assign out_port   = r_data | r_pulse;

  // Combinational read path; write-only registers read back DATA.
  always_comb begin
    w_rdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        AddrData, AddrSet, AddrClear, AddrToggle, AddrPulse: w_rdata[WIDTH-1:0] = r_data;
        AddrPulseLen: w_rdata[15:0] = r_pulse_len;
        AddrStatus:   w_rdata = {r_cnt, 15'd0, pulse_busy};
        default:      ;
      endcase
    end
  end

  assign bus.readdata = w_rdata;

endmodule
